// File: rtl/ds18b20_pkg.sv
// Shared encodings for the DS18B20 measurement sequencer.
package ds18b20_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } ow_op_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_NO_PRESENCE = 2'd1,
    ERR_CRC         = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_code_e;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST1,
    S_SKIP1,
    S_CONV,
    S_POLL,
    S_RST2,
    S_SKIP2,
    S_RDSP,
    S_READ,
    S_CHECK
  } seq_state_e;

  // Command byte shifted out by each byte-write state.
  function automatic logic [7:0] cmd_for_state(input seq_state_e s);
    case (s)
      S_SKIP1, S_SKIP2: return CMD_SKIP_ROM;
      S_CONV:           return CMD_CONVERT;
      S_RDSP:           return CMD_READ_SP;
      default:          return 8'h00;
    endcase
  endfunction

  // Successor of each byte-write state once its eighth bit is acknowledged.
  function automatic seq_state_e next_cmd_state(input seq_state_e s);
    case (s)
      S_SKIP1: return S_CONV;
      S_CONV:  return S_POLL;
      S_SKIP2: return S_RDSP;
      S_RDSP:  return S_READ;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/crc8_dallas.sv
// Serial Dallas/Maxim CRC8 (reflected polynomial 0x8C), one data bit per enabled cycle.
module crc8_dallas (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic       fb;
  logic [7:0] shifted;

  assign fb      = crc[0] ^ bit_in;
  assign shifted = {1'b0, crc[7:1]};

  // Shift one bit in per enable; clr restarts the running residue.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= fb ? (shifted ^ 8'h8C) : shifted;
    end
  end

endmodule

// File: rtl/ds18b20_seq.sv
// Command-level DS18B20 measurement sequencer driving an external one-wire bit engine.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start pulse or period tick
// S_RST1  | first bus reset, expects presence
// S_SKIP1 | writing SKIP ROM (0xCC)
// S_CONV  | writing CONVERT T (0x44)
// S_POLL  | read slots until the sensor returns 1 or the timeout expires
// S_RST2  | second bus reset, expects presence
// S_SKIP2 | writing SKIP ROM (0xCC)
// S_RDSP  | writing READ SCRATCHPAD (0xBE)
// S_READ  | 72 read slots, bytes 0..8 LSB first through the CRC
// S_CHECK | one cycle: publish temperature or flag CRC error
module ds18b20_seq
  import ds18b20_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES       = 12_000_000,
  parameter int unsigned CONV_TIMEOUT_CYCLES = 12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        ow_req,
  output logic [1:0]  ow_op,
  output logic        ow_wbit,
  input  logic        ow_ack,
  input  logic        ow_rbit,
  input  logic        ow_presence,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  // Down-counter reload values; loading PERIOD-1 at reset matches an up-counter cleared to 0.
  localparam logic [31:0] PER_LOAD = (PERIOD_CYCLES == 0) ? 32'd0 : 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TO_LOAD  = (CONV_TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(CONV_TIMEOUT_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic       req_q, req_d;
  ow_op_e     op_q, op_d;
  logic       wbit_q, wbit_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic       tv_q, tv_d;
  logic       err_q, err_d;
  err_code_e  code_q, code_d;
  logic [15:0] temp_q, temp_d;

  logic [31:0] per_cnt_q;
  logic [31:0] to_cnt_q;
  logic [15:0] shadow_q;
  logic        all_ones_q;

  logic        per_tick;
  logic        trigger;
  logic        launch;
  logic        ack_ok;
  logic        timed_out;
  logic        bit_done;
  logic        crc_en;
  logic [7:0]  cmd_byte;
  logic [7:0]  crc;

  assign per_tick   = (PERIOD_CYCLES != 0) && (per_cnt_q == 32'd0);
  assign trigger    = start || per_tick;
  assign ack_ok     = req_q && ow_ack;
  assign timed_out  = (state_q == S_POLL) && (to_cnt_q == 32'd0);
  assign busy       = (state_q != S_IDLE) || tv_q || err_q;

  assign ow_req     = req_q;
  assign ow_op      = op_q;
  assign ow_wbit    = wbit_q;
  assign temp       = temp_q;
  assign temp_valid = tv_q;
  assign err        = err_q;
  assign err_code   = code_q;

  crc8_dallas u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (launch),
    .en     (crc_en),
    .bit_in (ow_rbit),
    .crc    (crc)
  );

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      op_q       <= OP_RESET;
      wbit_q     <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      tv_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      temp_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      op_q       <= op_d;
      wbit_q     <= wbit_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tv_q       <= tv_d;
      err_q      <= err_d;
      code_q     <= code_d;
      temp_q     <= temp_d;
    end
  end

  // Next-state and request logic; a new request only goes out while req is low, so each ack is followed by one idle cycle.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    op_d       = op_q;
    wbit_d     = wbit_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tv_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    temp_d     = temp_q;
    launch     = 1'b0;
    crc_en     = 1'b0;
    cmd_byte   = cmd_for_state(state_q);
    bit_done   = (bit_cnt_q == 3'd7);

    case (state_q)
      S_IDLE: begin
        if (trigger && !busy) begin
          launch     = 1'b1;
          state_d    = S_RST1;
          req_d      = 1'b1;
          op_d       = OP_RESET;
          wbit_d     = 1'b0;
          code_d     = ERR_NONE;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 4'd0;
        end
      end

      S_RST1, S_RST2: begin
        if (ack_ok) begin
          req_d = 1'b0;
          if (!ow_presence) begin
            err_d   = 1'b1;
            code_d  = ERR_NO_PRESENCE;
            state_d = S_IDLE;
          end else begin
            state_d   = (state_q == S_RST1) ? S_SKIP1 : S_SKIP2;
            bit_cnt_d = 3'd0;
          end
        end else if (!req_q) begin
          req_d  = 1'b1;
          op_d   = OP_RESET;
          wbit_d = 1'b0;
        end
      end

      S_SKIP1, S_CONV, S_SKIP2, S_RDSP: begin
        if (ack_ok) begin
          req_d  = 1'b0;
          wbit_d = 1'b0;
          if (bit_done) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            state_d    = next_cmd_state(state_q);
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (!req_q) begin
          req_d  = 1'b1;
          op_d   = OP_WRITE;
          wbit_d = cmd_byte[bit_cnt_q];
        end
      end

      S_POLL: begin
        // A completed slot reporting done wins over a timeout in the same cycle.
        if (ack_ok) begin
          req_d = 1'b0;
          if (ow_rbit) begin
            state_d = S_RST2;
          end else if (timed_out) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_IDLE;
          end
        end else if (!req_q) begin
          if (timed_out) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_IDLE;
          end else begin
            req_d  = 1'b1;
            op_d   = OP_READ;
            wbit_d = 1'b0;
          end
        end
      end

      S_READ: begin
        if (ack_ok) begin
          req_d  = 1'b0;
          crc_en = 1'b1;
          if (bit_done) begin
            bit_cnt_d = 3'd0;
            if (byte_cnt_q == 4'd8) begin
              state_d = S_CHECK;
            end else begin
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (!req_q) begin
          req_d  = 1'b1;
          op_d   = OP_READ;
          wbit_d = 1'b0;
        end
      end

      S_CHECK: begin
        // All-ones data (bus stuck high) is rejected even if the residue happened to be zero.
        state_d = S_IDLE;
        if ((crc == 8'h00) && !all_ones_q) begin
          temp_d = shadow_q;
          tv_d   = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = ERR_CRC;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Period and poll-timeout down-counters, temperature shadow and stuck-bus detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_q  <= PER_LOAD;
      to_cnt_q   <= TO_LOAD;
      shadow_q   <= 16'h0000;
      all_ones_q <= 1'b1;
    end else begin
      if (per_cnt_q == 32'd0) begin
        per_cnt_q <= PER_LOAD;
      end else begin
        per_cnt_q <= per_cnt_q - 32'd1;
      end

      if (state_q != S_POLL) begin
        to_cnt_q <= TO_LOAD;
      end else if (to_cnt_q != 32'd0) begin
        to_cnt_q <= to_cnt_q - 32'd1;
      end

      if (launch) begin
        all_ones_q <= 1'b1;
      end else if (crc_en && !ow_rbit) begin
        all_ones_q <= 1'b0;
      end

      if (crc_en && (byte_cnt_q < 4'd2)) begin
        shadow_q[{byte_cnt_q[0], bit_cnt_q}] <= ow_rbit;
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_seq.sv
// Directed bench for ds18b20_seq with a behavioural one-wire bit-engine model.
module tb_ds18b20_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        ow_req;
  logic [1:0]  ow_op;
  logic        ow_wbit;
  logic        ow_ack = 1'b0;
  logic        ow_rbit = 1'b0;
  logic        ow_presence = 1'b0;
  logic [15:0] temp;
  logic        temp_valid;
  logic        err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  sp [9];
  logic        pres_val = 1'b1;
  int          poll_ones_at = 2;

  int          cyc = 0;
  int          wait_cnt = 0;
  int          m_resets = 0;
  int          m_polls = 0;
  int          m_reads = 0;
  int          m_writes = 0;
  logic [63:0] wr_log = '0;
  int          tv_cnt = 0;
  int          err_cnt = 0;
  int          launches = 0;
  int          launch_cyc = 0;
  int          prev_launch_cyc = 0;
  int          last_wr_cyc = 0;
  int          err_cyc = 0;
  logic        busy_at_err = 1'b0;
  logic        busy_after_err = 1'b0;
  logic        inject_ack = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_wbit = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_err = 1'b0;
  logic        prev_busy = 1'b0;
  logic [1:0]  prev_op = 2'b00;

  always #5 clk = ~clk;

  ds18b20_seq #(
    .PERIOD_CYCLES       (5000),
    .CONV_TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .ow_req      (ow_req),
    .ow_op       (ow_op),
    .ow_wbit     (ow_wbit),
    .ow_ack      (ow_ack),
    .ow_rbit     (ow_rbit),
    .ow_presence (ow_presence),
    .temp        (temp),
    .temp_valid  (temp_valid),
    .err         (err),
    .err_code    (err_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_sp(input logic [71:0] v);
    for (int i = 0; i < 9; i++) sp[i] = v[8*i +: 8];
  endtask

  // One clock: sample just after the edge, run monitors and the bit-engine model.
  task automatic step();
    logic [7:0] b;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_req && ow_req)
      check("hs_stable", {29'd0, ow_op, ow_wbit}, {29'd0, prev_op, prev_wbit});
    if (prev_ack)
      check("hs_gap", {31'd0, ow_req}, 32'd0);
    if (busy && !prev_busy) begin
      launches++;
      prev_launch_cyc = launch_cyc;
      launch_cyc = cyc;
      m_resets = 0; m_polls = 0; m_reads = 0; m_writes = 0; wr_log = '0;
    end
    if (prev_err) busy_after_err = busy;
    if (err) begin err_cnt++; err_cyc = cyc; busy_at_err = busy; end
    if (temp_valid) tv_cnt++;

    ow_ack = 1'b0;
    if (inject_ack) begin
      ow_ack = 1'b1;
      inject_ack = 1'b0;
      wait_cnt = 0;
    end else if (ow_req) begin
      if (wait_cnt == 4) begin
        wait_cnt = 0;
        ow_ack = 1'b1;
        case (ow_op)
          2'b00: begin ow_presence = pres_val; m_resets++; end
          2'b01: begin
            if (m_writes < 64) wr_log[m_writes] = ow_wbit;
            m_writes++;
            last_wr_cyc = cyc;
          end
          2'b10: begin
            if (m_resets == 1) begin
              ow_rbit = (m_polls == poll_ones_at);
              m_polls++;
            end else begin
              if (m_reads < 72) begin
                b = sp[m_reads / 8];
                ow_rbit = b[m_reads % 8];
              end else begin
                ow_rbit = 1'b1;
              end
              m_reads++;
            end
          end
          default: ow_rbit = 1'b0;
        endcase
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_req = ow_req; prev_op = ow_op; prev_wbit = ow_wbit;
    prev_ack = ow_ack; prev_err = err; prev_busy = busy;
  endtask

  task automatic launch_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_req"}, 32'(ow_req), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    check({tag, "_done"}, 32'(busy), 32'd0);
    repeat (2) step();
  endtask

  localparam logic [71:0] SP_GOOD = 72'h1C_10_0C_FF_7F_46_4B_05_50;

  initial begin
    int t0, e0, l0, n, d;
    load_sp(SP_GOOD);

    // reset values
    repeat (3) step();
    check("rst_req", 32'(ow_req), 32'd0);
    check("rst_op", 32'(ow_op), 32'd0);
    check("rst_wbit", 32'(ow_wbit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_temp", 32'(temp), 32'd0);
    check("rst_tv", 32'(temp_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // full successful measurement
    t0 = tv_cnt; e0 = err_cnt;
    launch_start("t1");
    wait_done("t1", 2000);
    check("t1_wbits", wr_log[31:0], 32'hBECC44CC);
    check("t1_nwrites", 32'(m_writes), 32'd32);
    check("t1_polls", 32'(m_polls), 32'd3);
    check("t1_resets", 32'(m_resets), 32'd2);
    check("t1_reads", 32'(m_reads), 32'd72);
    check("t1_temp", 32'(temp), 32'h0550);
    check("t1_tv", 32'(tv_cnt - t0), 32'd1);
    check("t1_err", 32'(err_cnt - e0), 32'd0);
    check("t1_code", 32'(err_code), 32'd0);

    // no presence on first reset
    pres_val = 1'b0;
    t0 = tv_cnt; e0 = err_cnt;
    launch_start("t2");
    wait_done("t2", 100);
    check("t2_err", 32'(err_cnt - e0), 32'd1);
    check("t2_code", 32'(err_code), 32'd1);
    check("t2_writes", 32'(m_writes), 32'd0);
    check("t2_busy_at_err", 32'(busy_at_err), 32'd1);
    check("t2_busy_after", 32'(busy_after_err), 32'd0);
    check("t2_temp", 32'(temp), 32'h0550);
    check("t2_tv", 32'(tv_cnt - t0), 32'd0);
    pres_val = 1'b1;

    // corrupted CRC byte
    sp[8] = 8'h1D;
    t0 = tv_cnt; e0 = err_cnt;
    launch_start("t3");
    check("t3_code_clr", 32'(err_code), 32'd0);
    wait_done("t3", 2000);
    check("t3_err", 32'(err_cnt - e0), 32'd1);
    check("t3_code", 32'(err_code), 32'd2);
    check("t3_temp", 32'(temp), 32'h0550);
    check("t3_tv", 32'(tv_cnt - t0), 32'd0);

    // bus stuck high
    load_sp({72{1'b1}});
    t0 = tv_cnt; e0 = err_cnt;
    launch_start("tff");
    wait_done("tff", 2000);
    check("tff_err", 32'(err_cnt - e0), 32'd1);
    check("tff_code", 32'(err_code), 32'd2);
    check("tff_temp", 32'(temp), 32'h0550);
    load_sp(SP_GOOD);

    // conversion timeout
    rst = 1'b1; repeat (2) step(); rst = 1'b0; step();
    poll_ones_at = -1;
    e0 = err_cnt;
    launch_start("t4");
    wait_done("t4", 1000);
    d = err_cyc - last_wr_cyc;
    check("t4_err", 32'(err_cnt - e0), 32'd1);
    check("t4_code", 32'(err_code), 32'd3);
    check("t4_no_rst2", 32'(m_resets), 32'd1);
    check("t4_lat_range", 32'(d >= 200 && d <= 207), 32'd1);
    check("t4_temp", 32'(temp), 32'd0);
    poll_ones_at = 2;

    // periodic launches, dropped start, reset during READ
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    l0 = launches; t0 = tv_cnt;
    n = 0;
    while (launches == l0 && n < 6000) begin step(); n++; end
    check("t5_launch1", 32'(launches - l0), 32'd1);
    repeat (100) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done("t5a", 2000);
    check("t5_no_extra", 32'(launches - l0), 32'd1);
    n = 0;
    while (launches == l0 + 1 && n < 6000) begin step(); n++; end
    check("t5_launch2", 32'(launches - l0), 32'd2);
    check("t5_interval", 32'(launch_cyc - prev_launch_cyc), 32'd5000);
    wait_done("t5b", 2000);
    check("t5_tv", 32'(tv_cnt - t0), 32'd2);

    launch_start("t5c");
    n = 0;
    while (m_reads < 20 && n < 2000) begin step(); n++; end
    check("t5_in_read", 32'(m_reads >= 20), 32'd1);
    t0 = tv_cnt; e0 = err_cnt;
    rst = 1'b1;
    step();
    check("t5_rst_req", 32'(ow_req), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    inject_ack = 1'b1;
    repeat (20) step();
    check("t5_late_req", 32'(ow_req), 32'd0);
    check("t5_late_busy", 32'(busy), 32'd0);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    check("t5_no_tv", 32'(tv_cnt - t0), 32'd0);
    check("t5_temp_clr", 32'(temp), 32'd0);

    t0 = tv_cnt;
    launch_start("t5d");
    wait_done("t5d", 2000);
    check("t5_clean_temp", 32'(temp), 32'h0550);
    check("t5_clean_tv", 32'(tv_cnt - t0), 32'd1);
    check("t5_clean_code", 32'(err_code), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
